// File: rtl/icache_line_drive.sv
// ---------------------------------------------------------------------------
// icache_line_drive
//
// Fetch-stage result driver for the instruction cache. Accepts a looked-up
// fetch request (hit/miss, PC, prediction info, hit line) and delivers
// {pc, inst, prediction} to decode. On a miss it runs an AXI4 INCR burst
// refill, assembles the line in a local buffer and writes it into a way
// chosen by a 16-bit Galois LFSR.
//
// Optional feature macro: ICACHE_EARLY_RESTART_EN
//   When defined, the requested word is delivered during the refill burst as
//   soon as its beat has been captured; the line write still happens after
//   rlast.
//
// Handshake semantics (both sides): a transfer happens in a cycle where
// valid and ready are both high at the rising clock edge. valid never
// depends on ready in this block; once raised, valid_post_o is held until
// accepted unless kill_i, hold_i (on branches) or reset intervene.
//
// Ports
//   clock, reset                 clock, synchronous active-high reset
//   valid_pre_i / ready_pre_o    request handshake from the lookup stage
//   valid_post_o / ready_post_i  result handshake towards decode
//   kill_i                       flush: discard the current request's result
//   hold_i, is_branch_i          delivery hold, only effective on branches
//   fail_i / flush_o             prediction failed / redirect pulse on accept
//   tar_hit_i, hit_line_i        lookup hit flag and hit line
//   araddr_i                     fetch PC
//   pvalid_i, ptaken_i, ptarget_i  prediction info in
//   pvalid_o, ptaken_o, ptarget_o  latched prediction info
//   pc_o, inst_o, fault_o        latched PC, selected word, refill error
//   wen_o, windex_o, wway_o, wtag_o, wdata_o  cache line write port
//   io_master_*                  AXI4 read address / read data channels
//   debug_state                  current FSM state (encoding of state_e)
// ---------------------------------------------------------------------------
module icache_line_drive #(
    parameter  int LINE_WORDS = 4,
    parameter  int SETS       = 16,
    parameter  int WAYS       = 8,
    parameter  int BUS_W      = 64,
    localparam int OFF_W      = $clog2(LINE_WORDS * 4),
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = 32 - IDX_W - OFF_W,
    localparam int LINE_W     = LINE_WORDS * 32,
    localparam int WAY_W      = $clog2(WAYS)
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    input  logic              kill_i,
    input  logic              hold_i,
    input  logic              is_branch_i,
    input  logic              fail_i,
    output logic              flush_o,

    input  logic              tar_hit_i,
    input  logic [LINE_W-1:0] hit_line_i,
    input  logic [31:0]       araddr_i,
    input  logic              pvalid_i,
    input  logic              ptaken_i,
    input  logic [31:0]       ptarget_i,

    output logic              pvalid_o,
    output logic              ptaken_o,
    output logic [31:0]       ptarget_o,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              fault_o,

    output logic              wen_o,
    output logic [IDX_W-1:0]  windex_o,
    output logic [WAY_W-1:0]  wway_o,
    output logic [TAG_W-1:0]  wtag_o,
    output logic [LINE_W-1:0] wdata_o,

    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [31:0]       io_master_araddr,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [BUS_W-1:0]  io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [3:0]        io_master_rid,

    output logic [2:0]        debug_state
);

    localparam int WI_W  = OFF_W - 2;   // word index within a line
    localparam int CNT_W = WI_W + 1;    // beat counter, can hold LINE_WORDS

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HIT_WAIT  = 3'd1,
        S_AR        = 3'd2,
        S_R         = 3'd3,
        S_MISS_WAIT = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q;
    logic              pvalid_q, ptaken_q;
    logic [31:0]       ptarget_q;
    logic [31:0]       buf_q [LINE_WORDS];
    logic [CNT_W-1:0]  cnt_q;
    logic              fault_q;
    logic              killed_q;
    logic [15:0]       lfsr_q;
    logic [WAY_W-1:0]  way_q;

    logic [WI_W-1:0]   word_sel;
    logic [31:0]       beat_word;
    logic              beat_keep;
    logic              deliver_gate;
    logic              early_ok;
    logic              early_done;
    logic [15:0]       lfsr_next;
    logic              unused_rid;

    assign unused_rid = ^io_master_rid;

    assign word_sel     = pc_q[OFF_W-1:2];
    assign deliver_gate = !(is_branch_i && hold_i);
    // Beats past the line length are dropped; rlast still ends the burst.
    assign beat_keep    = (state_q == S_R) && io_master_rvalid
                          && (cnt_q < CNT_W'(LINE_WORDS));
    assign lfsr_next    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Narrow 32-bit beats on a 64-bit bus arrive on the lane selected by
    // address bit 2, which for a line-aligned burst is the beat parity.
    generate
        if (BUS_W == 64) begin : g_lane64
            assign beat_word = cnt_q[0] ? io_master_rdata[63:32] : io_master_rdata[31:0];
        end else begin : g_lane32
            assign beat_word = io_master_rdata[31:0];
        end
    endgenerate

`ifdef ICACHE_EARLY_RESTART_EN
    logic word_ok_q;    // requested word has been captured during R
    logic delivered_q;  // requested word already accepted by decode
    assign early_ok   = word_ok_q && !delivered_q;
    assign early_done = delivered_q;
`else
    assign early_ok   = 1'b0;
    assign early_done = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        ready_pre_o       = 1'b0;
        valid_post_o      = 1'b0;
        wen_o             = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_araddr  = 32'h0;
        io_master_arid    = 4'h0;
        io_master_arlen   = 8'h0;
        io_master_arsize  = 3'b000;
        io_master_arburst = 2'b00;
        io_master_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_pre_o = 1'b1;
                if (valid_pre_i) begin
                    state_d = tar_hit_i ? S_HIT_WAIT : S_AR;
                end
            end

            S_HIT_WAIT: begin
                valid_post_o = !killed_q && !kill_i && deliver_gate;
                if (killed_q || kill_i || (valid_post_o && ready_post_i)) begin
                    state_d = S_IDLE;
                end
            end

            S_AR: begin
                io_master_arvalid = 1'b1;
                io_master_araddr  = {pc_q[31:OFF_W], {OFF_W{1'b0}}};
                io_master_arlen   = 8'(LINE_WORDS - 1);
                io_master_arsize  = 3'b010;
                io_master_arburst = 2'b01;
                if (io_master_arready) begin
                    state_d = S_R;
                end
            end

            S_R: begin
                io_master_rready = 1'b1;
                valid_post_o     = early_ok && !killed_q && !kill_i && deliver_gate;
                if (io_master_rvalid && io_master_rlast) begin
                    state_d = S_MISS_WAIT;
                end
            end

            S_MISS_WAIT: begin
                valid_post_o = !early_done && !killed_q && !kill_i && deliver_gate;
                // A killed or early-delivered line is still good memory, so
                // it is written back on every exit unless the refill faulted.
                if (early_done || killed_q || kill_i || (valid_post_o && ready_post_i)) begin
                    state_d = S_IDLE;
                    wen_o   = !fault_q;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign flush_o = valid_post_o && ready_post_i && is_branch_i && fail_i;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= 32'h0;
            pvalid_q  <= 1'b0;
            ptaken_q  <= 1'b0;
            ptarget_q <= 32'h0;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            killed_q  <= 1'b0;
            lfsr_q    <= 16'hACE1;
            way_q     <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                buf_q[i] <= 32'h0;
            end
`ifdef ICACHE_EARLY_RESTART_EN
            word_ok_q   <= 1'b0;
            delivered_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (valid_pre_i) begin
                        pc_q      <= araddr_i;
                        pvalid_q  <= pvalid_i;
                        ptaken_q  <= ptaken_i;
                        ptarget_q <= ptarget_i;
                        cnt_q     <= '0;
                        fault_q   <= 1'b0;
                        killed_q  <= 1'b0;
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            buf_q[i] <= hit_line_i[32*i +: 32];
                        end
`ifdef ICACHE_EARLY_RESTART_EN
                        word_ok_q   <= 1'b0;
                        delivered_q <= 1'b0;
`endif
                    end
                end

                S_AR: begin
                    if (kill_i) begin
                        killed_q <= 1'b1;
                    end
                    if (io_master_arready) begin
                        way_q  <= lfsr_q[WAY_W-1:0];
                        lfsr_q <= lfsr_next;
                    end
                end

                S_R: begin
                    // The burst is always drained; a kill only suppresses
                    // delivery of the result.
                    if (kill_i) begin
                        killed_q <= 1'b1;
                    end
                    if (io_master_rvalid && (io_master_rresp != 2'b00)) begin
                        fault_q <= 1'b1;
                    end
                    if (beat_keep) begin
                        buf_q[cnt_q[WI_W-1:0]] <= beat_word;
                        cnt_q                  <= cnt_q + CNT_W'(1);
`ifdef ICACHE_EARLY_RESTART_EN
                        if (cnt_q[WI_W-1:0] == word_sel) begin
                            word_ok_q <= 1'b1;
                        end
`endif
                    end
`ifdef ICACHE_EARLY_RESTART_EN
                    if (valid_post_o && ready_post_i) begin
                        delivered_q <= 1'b1;
                    end
`endif
                end

                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign pc_o      = pc_q;
    assign pvalid_o  = pvalid_q;
    assign ptaken_o  = ptaken_q;
    assign ptarget_o = ptarget_q;
    assign inst_o    = buf_q[word_sel];
    assign fault_o   = fault_q;
    assign windex_o  = pc_q[OFF_W+IDX_W-1:OFF_W];
    assign wtag_o    = pc_q[31:OFF_W+IDX_W];
    assign wway_o    = way_q;

    generate
        for (genvar g = 0; g < LINE_WORDS; g++) begin : g_wdata
            assign wdata_o[32*g +: 32] = buf_q[g];
        end
    endgenerate

    assign debug_state = state_q;

endmodule
